// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_ctrl
// Brief    : 4x3 matrix keypad scanner with press/release debounce and decode.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scan_ctrl #(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] Rows,
  output logic [2:0] Cols,
  output logic [3:0] Num,
  output logic       Enable,
  output logic       KeyHeld
);

  localparam int            c_DW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_DW-1:0] c_DWELL_MAX = c_DW'(SCAN_DIV - 1);
  localparam logic [7:0]    c_DB        = 8'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2
  } state_t;

  state_t          r_state, w_state_nx;
  logic [3:0]      r_rows_meta, r_rows_sync;
  logic [c_DW-1:0] r_dwell;
  logic [2:0]      r_cols, w_cols_nx;
  logic [3:0]      r_row, w_row_nx;
  logic [7:0]      r_match, w_match_nx;
  logic [7:0]      r_rel, w_rel_nx;
  logic [3:0]      r_num, w_num_nx;
  logic            r_enable, w_enable_nx;
  logic            r_keyheld, w_keyheld_nx;

  logic            w_tick;
  logic            w_onehot;
  logic [2:0]      w_cols_adv;
  logic [7:0]      w_match_inc;
  logic [7:0]      w_rel_inc;
  logic [3:0]      w_code;

  assign w_tick      = (r_dwell == c_DWELL_MAX);
  assign w_onehot    = (r_rows_sync != 4'd0) &&
                       ((r_rows_sync & (r_rows_sync - 4'd1)) == 4'd0);
  assign w_cols_adv  = {r_cols[1:0], r_cols[2]};
  assign w_match_inc = r_match + 8'd1;
  assign w_rel_inc   = r_rel + 8'd1;

  // Column is still the one the stored row was seen on, so decode from r_cols.
  always_comb begin
    w_code = 4'h0;
    case (r_row)
      4'b0001: w_code = r_cols[0] ? 4'h1 : (r_cols[1] ? 4'h2 : 4'h3);
      4'b0010: w_code = r_cols[0] ? 4'h4 : (r_cols[1] ? 4'h5 : 4'h6);
      4'b0100: w_code = r_cols[0] ? 4'h7 : (r_cols[1] ? 4'h8 : 4'h9);
      4'b1000: w_code = r_cols[0] ? 4'hA : (r_cols[1] ? 4'h0 : 4'hB);
      default: w_code = 4'h0;
    endcase
  end

  always_comb begin
    w_state_nx   = r_state;
    w_cols_nx    = r_cols;
    w_row_nx     = r_row;
    w_match_nx   = r_match;
    w_rel_nx     = r_rel;
    w_num_nx     = r_num;
    w_enable_nx  = 1'b0;
    w_keyheld_nx = r_keyheld;
    if (w_tick) begin
      case (r_state)
        ST_SCAN: begin
          if (w_onehot) begin
            w_row_nx   = r_rows_sync;
            w_match_nx = 8'd1;
            w_rel_nx   = 8'd0;
            w_state_nx = ST_DEBOUNCE;
          end else begin
            w_cols_nx = w_cols_adv;
          end
        end
        ST_DEBOUNCE: begin
          if (r_rows_sync == r_row) begin
            w_match_nx = w_match_inc;
            if (w_match_inc == c_DB) begin
              w_num_nx     = w_code;
              w_enable_nx  = 1'b1;
              w_keyheld_nx = 1'b1;
              w_rel_nx     = 8'd0;
              w_state_nx   = ST_PRESSED;
            end
          end else begin
            w_match_nx = 8'd0;
            w_cols_nx  = w_cols_adv;
            w_state_nx = ST_SCAN;
          end
        end
        ST_PRESSED: begin
          if (r_rows_sync == 4'd0) begin
            w_rel_nx = w_rel_inc;
            if (w_rel_inc == c_DB) begin
              w_rel_nx     = 8'd0;
              w_match_nx   = 8'd0;
              w_keyheld_nx = 1'b0;
              w_cols_nx    = w_cols_adv;
              w_state_nx   = ST_SCAN;
            end
          end else begin
            w_rel_nx = 8'd0;
          end
        end
        default: begin
          w_state_nx = ST_SCAN;
          w_cols_nx  = 3'b001;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_SCAN;
      r_rows_meta <= 4'd0;
      r_rows_sync <= 4'd0;
      r_dwell     <= '0;
      r_cols      <= 3'b001;
      r_row       <= 4'd0;
      r_match     <= 8'd0;
      r_rel       <= 8'd0;
      r_num       <= 4'h0;
      r_enable    <= 1'b0;
      r_keyheld   <= 1'b0;
    end else begin
      r_rows_meta <= Rows;
      r_rows_sync <= r_rows_meta;
      r_dwell     <= w_tick ? '0 : r_dwell + 1'b1;
      r_state     <= w_state_nx;
      r_cols      <= w_cols_nx;
      r_row       <= w_row_nx;
      r_match     <= w_match_nx;
      r_rel       <= w_rel_nx;
      r_num       <= w_num_nx;
      r_enable    <= w_enable_nx;
      r_keyheld   <= w_keyheld_nx;
    end
  end

  assign Cols    = r_cols;
  assign Num     = r_num;
  assign Enable  = r_enable;
  assign KeyHeld = r_keyheld;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scan_ctrl
// Brief    : Directed self-checking bench for keypad_scan_ctrl with a keypad model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] Rows;
  logic [2:0] Cols;
  logic [3:0] Num;
  logic       Enable;
  logic       KeyHeld;

  // keys[r][c] = 1 means the key at row r, column c is physically held
  logic [2:0] keys [4];

  int cyc     = 0;
  int pulses  = 0;
  int dbl     = 0;
  int errors  = 0;
  int checks  = 0;
  logic prev_en = 1'b0;

  keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Rows    (Rows),
    .Cols    (Cols),
    .Num     (Num),
    .Enable  (Enable),
    .KeyHeld (KeyHeld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int r = 0; r < 4; r++) Rows[r] = |(keys[r] & Cols);
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (Enable) begin
      pulses = pulses + 1;
      if (prev_en) dbl = dbl + 1;
    end
    prev_en = Enable;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cols(input logic [2:0] v, input int maxc, input string tag, output int at);
    bit found;
    found = 1'b0;
    at = -1;
    for (int i = 0; i < maxc && !found; i++) begin
      @(negedge clk);
      if (Cols === v) begin found = 1'b1; at = cyc; end
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_enable(input int maxc, input string tag, output int at);
    bit found;
    found = 1'b0;
    at = -1;
    for (int i = 0; i < maxc && !found; i++) begin
      @(negedge clk);
      if (Enable === 1'b1) begin found = 1'b1; at = cyc; end
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_release(input int maxc, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < maxc && !found; i++) begin
      @(negedge clk);
      if (KeyHeld === 1'b0) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic check_pulses(input string tag, input int exp);
    #1;
    check(tag, 32'(pulses), 32'(exp));
  endtask

  initial begin
    int t0;
    int t1;
    int base;
    for (int r = 0; r < 4; r++) keys[r] = 3'b000;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-scan, observed without any clock edge
    wait_cols(3'b010, 20, "reach_c2", t0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_cols",    32'(Cols),    32'h1);
    check("rst_num",     32'(Num),     32'h0);
    check("rst_enable",  32'(Enable),  32'h0);
    check("rst_keyheld", 32'(KeyHeld), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    base = cyc;
    #1 check("step_k0", 32'(Cols), 32'h1);
    repeat (3) @(negedge clk);
    check("step_k3", 32'(Cols), 32'h1);
    @(negedge clk);
    check("step_k4", 32'(Cols), 32'h2);
    repeat (4) @(negedge clk);
    check("step_k8", 32'(Cols), 32'h4);
    repeat (4) @(negedge clk);
    check("step_k12", 32'(Cols), 32'h1);
    check("step_cyc", 32'(cyc - base), 32'd12);

    // Clean press of key 5, held 60 cycles
    keys[1][1] = 1'b1;
    wait_cols(3'b010, 20, "k5_reach_c2", t0);
    wait_enable(40, "k5_enable_seen", t1);
    check("k5_latency", 32'(t1 - t0), 32'd12);
    check("k5_num",     32'(Num),     32'h5);
    check("k5_held",    32'(KeyHeld), 32'h1);
    repeat (44) @(negedge clk);
    check("k5_held_late", 32'(KeyHeld), 32'h1);
    check("k5_cols_fixed", 32'(Cols),   32'h2);
    check_pulses("k5_one_pulse", 1);
    keys[1][1] = 1'b0;
    wait_release(40, "k5_release_seen");
    check("k5_rel_cols", 32'(Cols), 32'h4);
    check("k5_rel_num",  32'(Num),  32'h5);
    repeat (20) @(negedge clk);
    check("k5_num_holds", 32'(Num), 32'h5);
    check_pulses("k5_still_one", 1);

    // Bounce: key 5 visible for a single C2 dwell
    wait_cols(3'b010, 20, "bnc_reach_c2", t0);
    keys[1][1] = 1'b1;
    repeat (4) @(negedge clk);
    keys[1][1] = 1'b0;
    repeat (4) @(negedge clk);
    check("bnc_resume_c3", 32'(Cols), 32'h4);
    repeat (30) @(negedge clk);
    check_pulses("bnc_no_pulse", 1);

    // Invalid: R1 and R3 both set on C1
    wait_cols(3'b001, 20, "inv_reach_c1", t0);
    keys[0][0] = 1'b1;
    keys[2][0] = 1'b1;
    repeat (40) @(negedge clk);
    check_pulses("inv_no_pulse", 1);
    check("inv_no_held", 32'(KeyHeld), 32'h0);
    keys[0][0] = 1'b0;
    keys[2][0] = 1'b0;

    // Star and hash codes
    keys[3][0] = 1'b1;
    wait_enable(60, "star_enable_seen", t1);
    check("star_num", 32'(Num), 32'hA);
    keys[3][0] = 1'b0;
    wait_release(40, "star_release_seen");
    keys[3][2] = 1'b1;
    wait_enable(60, "hash_enable_seen", t1);
    check("hash_num", 32'(Num), 32'hB);
    keys[3][2] = 1'b0;
    wait_release(40, "hash_release_seen");
    check_pulses("codes_pulses", 3);

    // Rollover: key 1 held, key 9 added, key 1 released
    keys[0][0] = 1'b1;
    wait_enable(60, "k1_enable_seen", t1);
    check("k1_num", 32'(Num), 32'h1);
    keys[2][2] = 1'b1;
    repeat (40) @(negedge clk);
    check("roll_num_still1", 32'(Num),     32'h1);
    check("roll_held",       32'(KeyHeld), 32'h1);
    check_pulses("roll_single", 4);
    keys[0][0] = 1'b0;
    wait_enable(100, "k9_enable_seen", t1);
    check("k9_num", 32'(Num), 32'h9);
    check_pulses("roll_second", 5);
    keys[2][2] = 1'b0;
    wait_release(40, "k9_release_seen");

    // Reset during DEBOUNCE after two matching samples
    wait_cols(3'b001, 20, "rd_reach_c1", t0);
    keys[1][1] = 1'b1;
    wait_cols(3'b010, 20, "rd_reach_c2", t0);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rd_cols",    32'(Cols),    32'h1);
    check("rd_num",     32'(Num),     32'h0);
    check("rd_enable",  32'(Enable),  32'h0);
    check("rd_keyheld", 32'(KeyHeld), 32'h0);
    repeat (5) @(negedge clk);
    check_pulses("rd_no_pulse", 5);
    rst_n = 1'b1;
    wait_cols(3'b010, 20, "rd2_reach_c2", t0);
    wait_enable(40, "rd2_enable_seen", t1);
    check("rd2_latency", 32'(t1 - t0), 32'd12);
    check("rd2_num",     32'(Num),     32'h5);
    keys[1][1] = 1'b0;
    wait_release(40, "rd2_release_seen");
    check_pulses("total_pulses", 6);
    check("no_double_enable", 32'(dbl), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan controller for the stopwatch's 4x3 matrix keypad. It drives the three column lines one at a time, samples the four row lines, debounces a single-key press and emits one `Enable` pulse per press with the decoded digit on `Num`. It sits between the keypad pins and the stopwatch entry/control logic and replaces free-running, undebounced combinational decode of the matrix.

## Interface
- `SCAN_DIV`, 4: clock cycles each column is driven (dwell); legal range >= 4 and <= 2^16.
- `DEBOUNCE_CNT`, 3: consecutive identical row samples required to accept a press or a release; legal range >= 2 and <= 255.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `Rows`  in  4  raw row lines, active-high; `Rows[0]`=R1 … `Rows[3]`=R4; asynchronous to `clk`.
- `Cols`  out  3  one-hot column drive, active-high; `Cols[0]`=C1, `Cols[1]`=C2, `Cols[2]`=C3.
- `Num`  out  4  code of the last accepted key; holds between presses.
- `Enable`  out  1  one-cycle pulse when a new key is accepted.
- `KeyHeld`  out  1  high while an accepted key has not yet been released.

## Operation
- Key codes (row, col): R1: 1,2,3; R2: 4,5,6; R3: 7,8,9; R4: C1=4'hA (`*`), C2=4'h0, C3=4'hB (`#`).
- `Rows` pass through a 2-flop synchronizer; all decisions use the synchronized value.
- A dwell counter runs 0..SCAN_DIV-1 per column. A "sample" is the synchronized row vector taken on the cycle the counter equals SCAN_DIV-1.
- States:
  - SCAN: sample != 0 and exactly one bit set -> store row and column, set match count = 1, go to DEBOUNCE, and keep the column. Otherwise advance the column C1->C2->C3->C1. Samples with multiple rows set are ignored.
  - DEBOUNCE: the column stays fixed. A sample equal to the stored row increments the match count. When the count reaches DEBOUNCE_CNT, load `Num`, pulse `Enable`, and go to PRESSED. Any other sample goes to SCAN and advances the column.
  - PRESSED: the column stays fixed and `KeyHeld`=1. An all-zero sample increments the release count. Any non-zero sample clears it. When the release count reaches DEBOUNCE_CNT, go to SCAN and advance the column.
- Only one key is ever tracked. Keys in other columns are invisible while DEBOUNCE or PRESSED hold their column.
- Autorepeat is not provided. One press produces exactly one `Enable` pulse.

## Timing
- Reset values: `Cols`=3'b001, `Num`=4'h0, `Enable`=0, `KeyHeld`=0, state SCAN, dwell counter 0, match and release counts 0, synchronizer flops 0.
- Reset applied mid-operation (any state) returns all of the above immediately and asynchronously. A pending press is discarded and no pulse is produced.
- `Cols` changes only on the cycle after a sample, so each column is driven for exactly SCAN_DIV cycles.
- `Enable` and the new `Num` are registered. Both appear on the cycle after the DEBOUNCE_CNT-th matching sample.
- Press latency from the first matching sample to `Enable`: (DEBOUNCE_CNT-1)*SCAN_DIV + 1 cycles.
- `KeyHeld` rises in the same cycle as `Enable`. It falls on the cycle after the DEBOUNCE_CNT-th zero sample, in the same cycle the column advances.
- `Enable` never stays high for 2 consecutive cycles.
- The minimum spacing between pulses is 2*DEBOUNCE_CNT*SCAN_DIV cycles.

## Test plan
- Reset: assert `rst_n`=0 mid-scan -> `Cols`=001, `Num`=0, `Enable`=0, `KeyHeld`=0 with no clock edge needed. After release, `Cols` steps 001->010->100->001 every 4 cycles.
- Clean press of R2/C2 (key 5) held 60 cycles (defaults) -> exactly one `Enable` pulse, 9 cycles after the first C2 sample. `Num`=5 and `KeyHeld`=1 until 3 zero samples follow release. `Num` stays 5 afterwards.
- Bounce: `Rows[1]` toggles high for a single C2 dwell, then stays low -> no `Enable` pulse, and scanning resumes at C3.
- Invalid: R1 and R3 both high in C1 -> no pulse. Codes `*` (R4/C1) and `#` (R4/C3) -> `Num`=4'hA and 4'hB respectively.
- Rollover: hold R1/C1 (key 1), then also press R3/C3 -> single pulse, `Num`=1. Release key 1 with key 9 still held -> key 9 is accepted on a later C3 scan, giving a second pulse with `Num`=9.
- Reset during DEBOUNCE after 2 matching samples -> no pulse. The same key held after reset is accepted normally with full latency.
